// File: rtl/lamp_safety_monitor.sv
// lamp_safety_monitor: checks one-hot lamp codes, phase transitions and dwell time, forcing HOLD on fault
module lamp_safety_monitor #(
  parameter int MAX_DWELL = 56,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] lampA_in,
  input  logic [3:0] lampB_in,
  input  logic       fault_clr,
  output logic [3:0] lampA_out,
  output logic [3:0] lampB_out,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir
);
  localparam logic [3:0] HOLD = 4'b0010;
  localparam logic [3:0] P1 = 4'b0100;
  localparam logic [3:0] P2 = 4'b1000;
  localparam logic [3:0] P3 = 4'b0001;
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(MAX_DWELL);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(MAX_DWELL - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  typedef enum logic [1:0] {ARM, RUN, FAULT} state_t;
  function automatic logic valid(input logic [3:0] c);
    return c == HOLD || c == P1 || c == P2 || c == P3;
  endfunction
  function automatic logic legal(input logic [3:0] p, input logic [3:0] n);
    return p == n || (p == HOLD && (n == P1 || n == P2)) || (p == P1 && n == HOLD) ||
           (p == P2 && n == P3) || (p == P3 && n == HOLD);
  endfunction
  function automatic logic [CNT_W-1:0] next_dwell(input logic [CNT_W-1:0] d, input logic same);
    return !same ? ONE : (d == '1 ? d : d + ONE);
  endfunction
  state_t state_q, state_d;
  logic [3:0] out_a_q, out_a_d, out_b_q, out_b_d, prev_a_q, prev_a_d, prev_b_q, prev_b_d;
  logic [CNT_W-1:0] dwell_a_q, dwell_a_d, dwell_b_q, dwell_b_d, arm_q, arm_d;
  logic fault_q, fault_d;
  logic [2:0] code_q, code_d, cause;
  logic [1:0] dir_q, dir_d, enc, trn, dwl, cause_dir;
  logic same_a, same_b;
  assign same_a = lampA_in == prev_a_q;
  assign same_b = lampB_in == prev_b_q;
  assign enc = {!valid(lampB_in), !valid(lampA_in)};
  assign trn = {!legal(prev_b_q, lampB_in), !legal(prev_a_q, lampA_in)};
  assign dwl = {same_b && dwell_b_q == DWELL_MAX, same_a && dwell_a_q == DWELL_MAX};
  assign cause = |enc ? 3'd1 : |trn ? 3'd2 : |dwl ? 3'd3 : 3'd0;
  assign cause_dir = |enc ? enc : |trn ? trn : dwl;
  always_comb begin
    state_d = state_q;
    out_a_d = HOLD;
    out_b_d = HOLD;
    prev_a_d = prev_a_q;
    prev_b_d = prev_b_q;
    dwell_a_d = dwell_a_q;
    dwell_b_d = dwell_b_q;
    arm_d = arm_q;
    fault_d = fault_q;
    code_d = code_q;
    dir_d = dir_q;
    case (state_q)
      ARM: begin
        if (lampA_in == HOLD && lampB_in == HOLD) begin
          state_d = RUN;
          prev_a_d = HOLD;
          prev_b_d = HOLD;
          dwell_a_d = ONE;
          dwell_b_d = ONE;
        end else if (arm_q == ARM_LAST) begin
          state_d = FAULT;
          fault_d = 1'b1;
          code_d = 3'd3;
          dir_d = 2'b11;
        end else begin
          arm_d = arm_q + ONE;
        end
      end
      RUN: begin
        if (cause != 3'd0) begin
          state_d = FAULT;
          fault_d = 1'b1;
          code_d = cause;
          dir_d = cause_dir;
        end else begin
          out_a_d = lampA_in;
          out_b_d = lampB_in;
          prev_a_d = lampA_in;
          prev_b_d = lampB_in;
          dwell_a_d = next_dwell(dwell_a_q, same_a);
          dwell_b_d = next_dwell(dwell_b_q, same_b);
        end
      end
      FAULT: begin
        if (fault_clr) begin
          state_d = ARM;
          fault_d = 1'b0;
          code_d = 3'd0;
          dir_d = 2'b00;
          arm_d = '0;
        end
      end
      default: state_d = ARM;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARM;
      out_a_q <= HOLD;
      out_b_q <= HOLD;
      prev_a_q <= HOLD;
      prev_b_q <= HOLD;
      dwell_a_q <= '0;
      dwell_b_q <= '0;
      arm_q <= '0;
      fault_q <= 1'b0;
      code_q <= 3'd0;
      dir_q <= 2'b00;
    end else begin
      state_q <= state_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      prev_a_q <= prev_a_d;
      prev_b_q <= prev_b_d;
      dwell_a_q <= dwell_a_d;
      dwell_b_q <= dwell_b_d;
      arm_q <= arm_d;
      fault_q <= fault_d;
      code_q <= code_d;
      dir_q <= dir_d;
    end
  end
  assign lampA_out = out_a_q;
  assign lampB_out = out_b_q;
  assign fault = fault_q;
  assign fault_code = code_q;
  assign fault_dir = dir_q;
endmodule

// File: tb/tb_lamp_safety_monitor.sv
// tb_lamp_safety_monitor: directed vector table plus multi-cycle sequences for lamp_safety_monitor
module tb_lamp_safety_monitor;
  localparam logic [3:0] H = 4'b0010;
  localparam logic [3:0] P1 = 4'b0100;
  localparam logic [3:0] P2 = 4'b1000;
  localparam logic [3:0] P3 = 4'b0001;
  logic clk = 1'b0, reset = 1'b1, fault_clr = 1'b0, fault;
  logic [3:0] lampA_in = H, lampB_in = H, lampA_out, lampB_out;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [3:0] a, b;
    logic clr;
    logic [3:0] ea, eb;
    logic ef;
    logic [2:0] ec;
    logic [1:0] ed;
  } vec_t;
  vec_t tbl[22];
  lamp_safety_monitor dut (
    .clk(clk), .reset(reset), .lampA_in(lampA_in), .lampB_in(lampB_in), .fault_clr(fault_clr),
    .lampA_out(lampA_out), .lampB_out(lampB_out), .fault(fault), .fault_code(fault_code),
    .fault_dir(fault_dir)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [3:0] ea, input logic [3:0] eb,
                     input logic ef, input logic [2:0] ec, input logic [1:0] ed);
    n_cmp++;
    if ({lampA_out, lampB_out, fault, fault_code, fault_dir} !== {ea, eb, ef, ec, ed}) begin
      n_bad++;
      $display("FAIL %s: got a=%b b=%b f=%b code=%0d dir=%b, want a=%b b=%b f=%b code=%0d dir=%b",
               name, lampA_out, lampB_out, fault, fault_code, fault_dir, ea, eb, ef, ec, ed);
    end
  endtask
  task automatic do_reset(input logic [3:0] a, input logic [3:0] b);
    reset = 1'b1;
    lampA_in = a;
    lampB_in = b;
    fault_clr = 1'b0;
    step();
    chk("reset_state", H, H, 1'b0, 3'd0, 2'b00);
    reset = 1'b0;
  endtask
  function automatic logic [3:0] phase(input int t);
    return t < 3 ? H : t < 27 ? P1 : t < 31 ? H : t < 39 ? P2 : t < 55 ? P3 : H;
  endfunction
  initial begin
    tbl[0] = '{H, H, 1'b0, H, H, 1'b0, 3'd0, 2'b00};
    tbl[1] = '{P1, H, 1'b0, P1, H, 1'b0, 3'd0, 2'b00};
    tbl[2] = '{4'b0110, H, 1'b0, H, H, 1'b1, 3'd1, 2'b01};
    tbl[3] = '{P1, P1, 1'b0, H, H, 1'b1, 3'd1, 2'b01};
    tbl[4] = '{4'b0110, H, 1'b1, H, H, 1'b0, 3'd0, 2'b00};
    tbl[5] = '{H, H, 1'b0, H, H, 1'b0, 3'd0, 2'b00};
    tbl[6] = '{P3, 4'b0000, 1'b0, H, H, 1'b1, 3'd1, 2'b10};
    tbl[7] = '{H, H, 1'b1, H, H, 1'b0, 3'd0, 2'b00};
    tbl[8] = '{H, H, 1'b0, H, H, 1'b0, 3'd0, 2'b00};
    tbl[9] = '{P1, P1, 1'b0, P1, P1, 1'b0, 3'd0, 2'b00};
    tbl[10] = '{P2, H, 1'b0, H, H, 1'b1, 3'd2, 2'b01};
    tbl[11] = '{H, H, 1'b1, H, H, 1'b0, 3'd0, 2'b00};
    tbl[12] = '{H, H, 1'b0, H, H, 1'b0, 3'd0, 2'b00};
    tbl[13] = '{P2, P2, 1'b0, P2, P2, 1'b0, 3'd0, 2'b00};
    tbl[14] = '{H, P1, 1'b0, H, H, 1'b1, 3'd2, 2'b11};
    tbl[15] = '{H, H, 1'b1, H, H, 1'b0, 3'd0, 2'b00};
    tbl[16] = '{H, H, 1'b0, H, H, 1'b0, 3'd0, 2'b00};
    tbl[17] = '{P2, P2, 1'b0, P2, P2, 1'b0, 3'd0, 2'b00};
    tbl[18] = '{P3, P3, 1'b0, P3, P3, 1'b0, 3'd0, 2'b00};
    tbl[19] = '{H, P3, 1'b0, H, P3, 1'b0, 3'd0, 2'b00};
    tbl[20] = '{H, H, 1'b0, H, H, 1'b0, 3'd0, 2'b00};
    tbl[21] = '{H, P1, 1'b1, H, P1, 1'b0, 3'd0, 2'b00};
    do_reset(H, H);
    for (int i = 0; i < 22; i++) begin
      lampA_in = tbl[i].a;
      lampB_in = tbl[i].b;
      fault_clr = tbl[i].clr;
      step();
      chk($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].ef, tbl[i].ec, tbl[i].ed);
    end
    do_reset(H, H);
    for (int t = 0; t < 86; t++) begin
      lampA_in = phase(t);
      lampB_in = phase(t - 28);
      step();
      chk($sformatf("seq_t%0d", t), phase(t), phase(t - 28), 1'b0, 3'd0, 2'b00);
    end
    do_reset(H, H);
    step();
    lampB_in = P1;
    for (int k = 1; k <= 57; k++) begin
      lampA_in = k[0] ? P1 : H;
      step();
      if (k == 56) chk("dwell_56", H, P1, 1'b0, 3'd0, 2'b00);
    end
    chk("dwell_57", H, H, 1'b1, 3'd3, 2'b10);
    lampA_in = 4'b0110;
    lampB_in = 4'b1111;
    fault_clr = 1'b1;
    step();
    chk("clr_to_arm", H, H, 1'b0, 3'd0, 2'b00);
    fault_clr = 1'b0;
    for (int k = 1; k <= 56; k++) begin
      step();
      if (k == 55) chk("arm_55", H, H, 1'b0, 3'd0, 2'b00);
    end
    chk("arm_timeout", H, H, 1'b1, 3'd3, 2'b11);
    do_reset(H, H);
    step();
    lampA_in = P2;
    lampB_in = P2;
    step();
    step();
    chk("pre_reset_p2", P2, P2, 1'b0, 3'd0, 2'b00);
    do_reset(P2, P2);
    step();
    chk("arm_p2", H, H, 1'b0, 3'd0, 2'b00);
    lampA_in = H;
    step();
    lampA_in = P1;
    lampB_in = P1;
    step();
    chk("arm_half_hold", H, H, 1'b0, 3'd0, 2'b00);
    lampA_in = H;
    lampB_in = H;
    step();
    lampA_in = P1;
    lampB_in = P1;
    step();
    chk("rerun", P1, P1, 1'b0, 3'd0, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
